// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access with base+offset addressing,
// range checking and a response that is held until the consumer takes it.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_r;
    logic                write_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [ADDR_W:0]     eff_s;
    logic                accept_s;

    // Base plus sign-extended offset in ADDR_W+1 bits. Every out-of-range result
    // (negative, or past the top of memory) lands with the extra top bit set.
    function automatic logic [ADDR_W:0] eff_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] offset);
        eff_addr = {1'b0, base} + {offset[ADDR_W-1], offset};
    endfunction

    // Accept decode and effective address of the presented request.
    always_comb begin
        accept_s = req_valid && req_ready;
        eff_s    = eff_addr(req_base, req_offset);
    end

    // Control FSM; every output is a register updated on the state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            write_r        <= 1'b0;
            wdata_r        <= {DATA_W{1'b0}};
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_data      <= {DATA_W{1'b0}};
            resp_err       <= 1'b0;
            mem_read_write <= 1'b0;
            mem_addr       <= {ADDR_W{1'b0}};
            mem_wdata      <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r   <= req_write;
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        if (eff_s[ADDR_W]) begin
                            // Bad address: answer at once and leave memory alone.
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= {DATA_W{1'b0}};
                        end else begin
                            state_r        <= ACCESS;
                            mem_addr       <= eff_s[ADDR_W-1:0];
                            mem_read_write <= req_write;
                            if (req_write) begin
                                mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    mem_read_write <= 1'b0;
                    state_r        <= CAPTURE;
                end
                CAPTURE: begin
                    resp_data  <= write_r ? wdata_r : mem_rdata;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    req_ready      <= 1'b1;
                    resp_valid     <= 1'b0;
                    mem_read_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued at accept
// time from a reference memory and compared when the response appears.
module tb_load_store_unit;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W-1:0] req_offset;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              mem_read_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              cur;
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];
    int                wr_count = 0;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_read_write(mem_read_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: combinational read, write on the edge while the enable is high.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_read_write) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compute the expected response independently of the DUT and queue it.
    task automatic push_exp(input logic wr, input logic [7:0] base, input logic [7:0] off,
                            input logic [15:0] wdata);
        int   ea;
        exp_t e;
        ea = int'(base) + int'($signed(off));
        if (ea < 0 || ea > 255) begin
            e.err  = 1'b1;
            e.data = 16'h0000;
        end else begin
            e.err = 1'b0;
            if (wr) begin
                ref_mem[ea] = wdata;
                e.data      = wdata;
            end else begin
                e.data = ref_mem[ea];
            end
        end
        exp_q.push_back(e);
    endtask

    // Present one request from IDLE; returns just after the accept edge with inputs scrambled.
    task automatic issue(input logic wr, input logic [7:0] base, input logic [7:0] off,
                         input logic [15:0] wdata);
        req_write  = wr;
        req_base   = base;
        req_offset = off;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        push_exp(wr, base, off, wdata);
        tick();
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_base   = 8'($urandom);
        req_offset = 8'($urandom);
        req_wdata  = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_data !== 16'h0000 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got %h/%b expected 0000/0", resp_data, resp_err); end
        checks++; if (mem_read_write !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem: got %b/%h/%h expected 0/00/0000", mem_read_write, mem_addr, mem_wdata); end
    endtask

    task automatic test_store();
        int w0;
        w0 = wr_count;
        issue(1'b1, 8'h10, 8'h05, 16'hBEEF);
        checks++; if (mem_read_write !== 1'b1 || mem_addr !== 8'h15 || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL store_access: got we=%b addr=%h wdata=%h expected 1/15/beef", mem_read_write, mem_addr, mem_wdata); end
        tick();
        checks++; if (mem_read_write !== 1'b0 || mem_addr !== 8'h15 || resp_valid !== 1'b0) begin errors++; $display("FAIL store_capture: got we=%b addr=%h rv=%b expected 0/15/0", mem_read_write, mem_addr, resp_valid); end
        tick();
        cur = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_data !== cur.data || resp_err !== cur.err) begin errors++; $display("FAIL store_resp: got rv=%b data=%h err=%b expected 1/%h/%b", resp_valid, resp_data, resp_err, cur.data, cur.err); end
        checks++; if (wr_count - w0 !== 1 || mem[8'h15] !== 16'hBEEF) begin errors++; $display("FAIL store_mem: got writes=%0d mem=%h expected 1/beef", wr_count - w0, mem[8'h15]); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL store_done: got rv=%b rr=%b expected 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_load();
        int w0;
        w0 = wr_count;
        issue(1'b0, 8'h20, 8'hFE, 16'hFFFF);
        checks++; if (mem_read_write !== 1'b0 || mem_addr !== 8'h1E) begin errors++; $display("FAIL load_access: got we=%b addr=%h expected 0/1e", mem_read_write, mem_addr); end
        tick();
        checks++; if (mem_read_write !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL load_capture: got we=%b rv=%b expected 0/0", mem_read_write, resp_valid); end
        tick();
        cur = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_data !== cur.data || resp_err !== cur.err) begin errors++; $display("FAIL load_resp: got rv=%b data=%h err=%b expected 1/%h/%b", resp_valid, resp_data, resp_err, cur.data, cur.err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if (wr_count !== w0 || resp_valid !== 1'b0) begin errors++; $display("FAIL load_done: got writes=%0d rv=%b expected %0d/0", wr_count, resp_valid, w0); end
    endtask

    task automatic test_out_of_range();
        int w0;
        w0 = wr_count;
        issue(1'b1, 8'hFF, 8'h01, 16'hAAAA);
        cur = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_err !== cur.err || resp_data !== cur.data) begin errors++; $display("FAIL oor_high: got rv=%b err=%b data=%h expected 1/%b/%h", resp_valid, resp_err, resp_data, cur.err, cur.data); end
        checks++; if (mem_read_write !== 1'b0 || mem_addr !== 8'h1E) begin errors++; $display("FAIL oor_mem: got we=%b addr=%h expected 0/1e", mem_read_write, mem_addr); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tick();
        issue(1'b0, 8'h00, 8'hFF, 16'h0000);
        cur = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_err !== cur.err || resp_data !== cur.data) begin errors++; $display("FAIL oor_low: got rv=%b err=%b data=%h expected 1/%b/%h", resp_valid, resp_err, resp_data, cur.err, cur.data); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if (wr_count !== w0 || resp_valid !== 1'b0) begin errors++; $display("FAIL oor_writes: got writes=%0d rv=%b expected %0d/0", wr_count, resp_valid, w0); end
    endtask

    task automatic test_backpressure();
        issue(1'b0, 8'h15, 8'h00, 16'h0000);
        tick();
        tick();
        cur = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_base   = 8'h30;
            req_offset = 8'h00;
            req_wdata  = 16'h7777;
            checks++; if (resp_valid !== 1'b1 || resp_data !== cur.data || resp_err !== cur.err || req_ready !== 1'b0 || mem_read_write !== 1'b0) begin
                errors++; $display("FAIL stall_%0d: got rv=%b data=%h err=%b rr=%b we=%b expected 1/%h/%b/0/0", i, resp_valid, resp_data, resp_err, req_ready, mem_read_write, cur.data, cur.err);
            end
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem[8'h30] === 16'h7777) begin errors++; $display("FAIL stall_release: got rv=%b rr=%b mem30=%h expected 0/1/not 7777", resp_valid, req_ready, mem[8'h30]); end
    endtask

    task automatic test_reset_in_access();
        issue(1'b1, 8'h40, 8'h00, 16'h5555);
        void'(exp_q.pop_back());
        checks++; if (mem_read_write !== 1'b1) begin errors++; $display("FAIL rst_pre: got we=%b expected 1", mem_read_write); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (mem_read_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_access: got we=%b rv=%b rr=%b expected 0/0/1", mem_read_write, resp_valid, req_ready); end
        tick();
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_noresp: got rv=%b expected 0", resp_valid); end
        issue(1'b0, 8'h40, 8'h00, 16'h0000);
        tick();
        tick();
        cur = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_data !== cur.data || resp_err !== cur.err) begin errors++; $display("FAIL rst_followup: got rv=%b data=%h err=%b expected 1/%h/%b", resp_valid, resp_data, resp_err, cur.data, cur.err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_base   = 8'h50;
        req_offset = 8'h03;
        req_wdata  = 16'hC0DE;
        push_exp(1'b1, 8'h50, 8'h03, 16'hC0DE);
        tick();
        req_write  = 1'b0;
        req_base   = 8'h60;
        req_offset = 8'hF3;
        req_wdata  = 16'h0000;
        tick();
        tick();
        cur = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_data !== cur.data || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_first: got rv=%b data=%h rr=%b expected 1/%h/0", resp_valid, resp_data, req_ready, cur.data); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got rv=%b rr=%b expected 0/1", resp_valid, req_ready); end
        push_exp(1'b0, 8'h60, 8'hF3, 16'h0000);
        tick();
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || mem_addr !== 8'h53) begin errors++; $display("FAIL b2b_accept: got rr=%b addr=%h expected 0/53", req_ready, mem_addr); end
        tick();
        tick();
        cur = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_data !== cur.data || resp_err !== cur.err) begin errors++; $display("FAIL b2b_second: got rv=%b data=%h err=%b expected 1/%h/%b", resp_valid, resp_data, resp_err, cur.data, cur.err); end
        tick();
        resp_ready = 1'b0;
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 3 + 1);
            ref_mem[i] = 16'(i * 3 + 1);
        end
        mem[8'h1E]     = 16'h1234;
        ref_mem[8'h1E] = 16'h1234;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_base   = 8'h00;
        req_offset = 8'h00;
        req_wdata  = 16'h0000;
        resp_ready = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_out_of_range();
        test_backpressure();
        test_reset_in_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, the data-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, the data-memory word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, asserting that the execute stage presents a request.
REQ-006 The block SHALL have port req_ready, output, 1, indicating the block accepts a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1, selecting a store (1) or a load (0).
REQ-008 The block SHALL have port req_base, input, ADDR_W, the unsigned base address.
REQ-009 The block SHALL have port req_offset, input, ADDR_W, the two's-complement signed offset.
REQ-010 The block SHALL have port req_wdata, input, DATA_W, the store data.
REQ-011 The block SHALL have port resp_valid, output, 1, indicating a completed access.
REQ-012 The block SHALL have port resp_ready, input, 1, indicating the consumer takes the response.
REQ-013 The block SHALL have port resp_data, output, DATA_W, carrying load data or the echoed store data.
REQ-014 The block SHALL have port resp_err, output, 1, flagging an out-of-range effective address.
REQ-015 The block SHALL have port mem_read_write, output, 1, the memory write enable (1 = write).
REQ-016 The block SHALL have port mem_addr, output, ADDR_W, the memory address.
REQ-017 The block SHALL have port mem_wdata, output, DATA_W, the data written to memory.
REQ-018 The block SHALL have port mem_rdata, input, DATA_W, the data read back from memory.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, CAPTURE and RESP; req_ready SHALL equal 1 only in IDLE.
REQ-020 A request SHALL be accepted on the edge where req_valid&&req_ready; base, offset, write and wdata SHALL be latched then, and later input changes SHALL be ignored.
REQ-021 Effective address SHALL be the (ADDR_W+1)-bit sum base + sign-extended offset; it is out of range if the sum is below 0 or above 2^ADDR_W-1, with no wrap-around.
REQ-022 On accept with an in-range address, the FSM SHALL go to ACCESS; with an out-of-range address, it SHALL go directly to RESP with resp_err=1 and resp_data=0, and memory SHALL be untouched.
REQ-023 In ACCESS, mem_addr SHALL hold the effective address; for stores, mem_wdata SHALL hold the latched wdata and mem_read_write SHALL be 1 for exactly this one cycle.
REQ-024 The FSM SHALL go ACCESS -> CAPTURE unconditionally, with mem_read_write=0 and mem_addr held.
REQ-025 In CAPTURE, loads SHALL register mem_rdata into resp_data and stores SHALL register the latched wdata; the FSM SHALL go CAPTURE -> RESP unconditionally.
REQ-026 In RESP, resp_valid SHALL be 1 and resp_data/resp_err SHALL be stable until the edge where resp_ready=1; then the FSM SHALL go to IDLE and resp_valid SHALL drop to 0.
REQ-027 In-range latency SHALL be 3 cycles from the accept edge to resp_valid=1; out-of-range latency SHALL be 1 cycle.
REQ-028 A new request SHALL NOT be accepted in the cycle resp_valid falls; the earliest next accept is the following cycle, in IDLE.
REQ-029 mem_read_write, mem_addr and mem_wdata SHALL be registered outputs, and mem_read_write SHALL be 0 in every state except a store's ACCESS.
REQ-030 mem_addr SHALL retain its last value in IDLE.

Reset
REQ-031 When rst=1 at an edge, the FSM SHALL go to IDLE and all outputs SHALL take their reset values: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_read_write=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset in any state, including ACCESS, SHALL discard the in-flight request with no response.
REQ-033 When reset takes effect during a store's ACCESS cycle, mem_read_write SHALL be 0 from the following cycle.

Verification
REQ-034 The bench SHALL cover: store base=0x10, offset=0x05, wdata=0xBEEF -> one cycle with mem_read_write=1 and mem_addr=0x15; resp_valid 3 cycles after accept with resp_data=0xBEEF and resp_err=0.
REQ-035 The bench SHALL cover: load base=0x20, offset=0xFE (-2), with the memory model returning 0x1234 at 0x1E -> mem_read_write stays 0; resp_data=0x1234 at resp_valid.
REQ-036 The bench SHALL cover: base=0xFF, offset=0x01 -> resp_err=1 and resp_data=0 one cycle after accept, with no memory write; base=0x00, offset=0xFF -> resp_err=1.
REQ-037 The bench SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid, resp_data and resp_err stable throughout, req_ready=0, and req_valid ignored.
REQ-038 The bench SHALL cover: rst asserted during a store's ACCESS cycle -> next cycle IDLE, mem_read_write=0, no resp_valid, and a subsequent load completes normally.
REQ-039 The bench SHALL cover: back-to-back requests with req_valid held high -> second accept exactly one cycle after the first resp_valid falls.
